// File: rtl/writeback_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | writeback_buffer                                                         |
// | Circular FIFO of pending register-file writes with bypass lookup.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module writeback_buffer #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [ADDR_WIDTH-1:0]   InRd,
    input  logic [WIDTH-1:0]        InData,
    input  logic                    WbEnable,
    output logic                    RegWrite,
    output logic [ADDR_WIDTH-1:0]   Rd,
    output logic [WIDTH-1:0]        WriteData,
    input  logic [ADDR_WIDTH-1:0]   Rs1,
    input  logic [ADDR_WIDTH-1:0]   Rs2,
    output logic                    Fwd1Valid,
    output logic                    Fwd2Valid,
    output logic [WIDTH-1:0]        Fwd1Data,
    output logic [WIDTH-1:0]        Fwd2Data,
    output logic [$clog2(DEPTH):0]  Count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_rd_mem   [DEPTH];
    logic [WIDTH-1:0]      r_data_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [c_PTR_W-1:0]    w_idx;

    assign w_empty  = (r_count == '0);
    assign InReady  = (r_count < c_DEPTH);
    assign RegWrite = !w_empty && WbEnable;
    assign Rd       = w_empty ? '0 : r_rd_mem[r_head];
    assign WriteData = w_empty ? '0 : r_data_mem[r_head];
    assign Count    = r_count;

    // Writes to x0 complete the handshake but never occupy an entry.
    assign w_push = InValid && InReady && (InRd != '0);
    assign w_pop  = RegWrite;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_mem[r_tail]   <= InRd;
            r_data_mem[r_tail] <= InData;
        end
    end

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        Fwd1Valid = 1'b0;
        Fwd1Data  = '0;
        Fwd2Valid = 1'b0;
        Fwd2Data  = '0;
        w_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + c_PTR_W'(k);
            if (c_CNT_W'(k) < r_count) begin
                if ((Rs1 != '0) && (r_rd_mem[w_idx] == Rs1)) begin
                    Fwd1Valid = 1'b1;
                    Fwd1Data  = r_data_mem[w_idx];
                end
                if ((Rs2 != '0) && (r_rd_mem[w_idx] == Rs2)) begin
                    Fwd2Valid = 1'b1;
                    Fwd2Data  = r_data_mem[w_idx];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of each result.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: register index width (32 registers).
REQ-003 SHALL have parameter DEPTH, default 4: number of buffered results; power of two, minimum 2.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port InValid  input  1  producer presents a result.
REQ-007 SHALL have port InReady  output  1  buffer can accept a result this cycle.
REQ-008 SHALL have port InRd  input  ADDR_WIDTH  destination register of the offered result.
REQ-009 SHALL have port InData  input  WIDTH  result value.
REQ-010 SHALL have port WbEnable  input  1  register file write port available; 0 stalls draining.
REQ-011 SHALL have port RegWrite  output  1  write enable to the register file.
REQ-012 SHALL have port Rd  output  ADDR_WIDTH  write address to the register file.
REQ-013 SHALL have port WriteData  output  WIDTH  write data to the register file.
REQ-014 SHALL have ports Rs1, Rs2  input  ADDR_WIDTH  read indices for bypass lookup.
REQ-015 SHALL have ports Fwd1Valid, Fwd2Valid  output  1  a pending entry matches Rs1 / Rs2.
REQ-016 SHALL have ports Fwd1Data, Fwd2Data  output  WIDTH  value of the matching pending entry.
REQ-017 SHALL have port Count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 SHALL be a circular FIFO with head/tail pointers wrapping modulo DEPTH and an occupancy counter.
REQ-019 SHALL drive InReady = (Count < DEPTH); InReady SHALL NOT depend on a same-cycle drain.
REQ-020 SHALL accept a result at a rising edge when InValid=1 and InReady=1.
REQ-021 SHALL discard an accepted result with InRd=0 (handshake completes, no entry, Count unchanged).
REQ-022 SHALL present the head entry combinationally: RegWrite = (Count != 0) AND WbEnable; Rd/WriteData = head fields.
REQ-023 SHALL drive Rd=0 and WriteData=0 when Count=0.
REQ-024 SHALL pop the head at a rising edge when RegWrite=1.
REQ-025 Latency: result accepted at edge N on an empty buffer with WbEnable=1 SHALL show RegWrite=1 during cycle N..N+1 and retire at edge N+1.
REQ-026 Simultaneous push and pop SHALL leave Count unchanged; the popped entry is the prior head.
REQ-027 Writes SHALL retire strictly in acceptance order, one per cycle maximum.
REQ-028 With WbEnable=0, entries SHALL be held; with Count=DEPTH, InReady SHALL be 0 and InValid ignored.
REQ-029 Bypass: FwdXValid=1 iff RsX != 0 and some occupied entry has Rd = RsX; FwdXData = youngest such entry's data.
REQ-030 FwdXValid=0 and FwdXData=0 when no match or RsX=0.
REQ-031 Bypass SHALL include the head entry even in the cycle it retires; it SHALL NOT include the result being offered on InData.
REQ-032 Duplicate Rd values in the buffer SHALL be legal; each SHALL retire separately, in order.

Reset
REQ-033 While rst=0: Count=0, pointers=0, RegWrite=0, Rd=0, WriteData=0, FwdXValid=0, FwdXData=0, InReady=1, taking effect immediately without a clock edge.
REQ-034 Reset asserted mid-operation SHALL discard all pending entries; none SHALL be written after release.
REQ-035 First acceptance SHALL be possible at the first rising edge with rst=1.

Verification
REQ-036 Empty, WbEnable=1, push (InRd=5, InData=0x64) -> next cycle RegWrite=1, Rd=5, WriteData=0x64; after following edge Count=0, RegWrite=0.
REQ-037 WbEnable=0, push rd 1..4 with data 0x68,0x6C,0x70,0x74 -> Count=4, InReady=0, 5th offer ignored; WbEnable=1 -> Rd 1,2,3,4 on four consecutive cycles, in order.
REQ-038 Push InRd=0, InData=0xDEADBEEF -> handshake completes, Count stays 0, RegWrite never asserts.
REQ-039 WbEnable=0, push (7,0xA),(7,0xB), Rs1=7, Rs2=0 -> Fwd1Valid=1, Fwd1Data=0xB, Fwd2Valid=0; drain -> Rd=7 writes 0xA then 0xB.
REQ-040 Count=3 with WbEnable=1 and continuous InValid -> Count stays 3 each cycle, pointers wrap past DEPTH-1 with no loss or reordering.
REQ-041 Buffer holding 3 entries, drop rst to 0 between edges -> RegWrite=0 and Count=0 immediately; after release no stale writes appear.
